// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard controller: FSM state encodings,
// output patterns {ctrl_zero, ifid_stall, pc_stall, flush} and a sizing helper.
package hazard_control_unit_pkg;

  localparam logic [1:0] HZ_IDLE   = 2'd0;
  localparam logic [1:0] HZ_LSTALL = 2'd1;
  localparam logic [1:0] HZ_FLUSH  = 2'd2;

  localparam logic [3:0] HZ_OUT_STALL = 4'b1110;
  localparam logic [3:0] HZ_OUT_FLUSH = 4'b1101;
  localparam logic [3:0] HZ_OUT_NONE  = 4'b0000;

  function automatic int hz_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_countdown.sv
// Loadable down-counter that holds the remaining stall/flush cycles.
// Decrement stops at zero; zero flag is combinational.
module hazard_countdown #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use / redirect hazard controller with multi-cycle stall and flush hold.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
//
// state      | meaning
// HZ_IDLE    | no hazard in progress; detect load-use and redirects
// HZ_LSTALL  | holding a load-use stall beyond its first cycle
// HZ_FLUSH   | holding a redirect flush beyond its first cycle
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1
`ifdef HAZARD_PERF_CNT_EN
  , parameter int PERF_CNT_W      = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read_idex_i,
  input  logic [REG_ADDR_W-1:0] rt_idex_i,
  input  logic [REG_ADDR_W-1:0] rs_ifid_i,
  input  logic [REG_ADDR_W-1:0] rt_ifid_i,
  input  logic                  rs_used_i,
  input  logic                  rt_used_i,
  input  logic                  branch_i,
  input  logic                  jmp_i,
  input  logic                  topc_i,
  output logic                  pc_stall_o,
  output logic                  ifid_stall_o,
  output logic                  ctrl_zero_o,
  output logic                  flush_o
`ifdef HAZARD_PERF_CNT_EN
  , output logic [PERF_CNT_W-1:0] stall_cnt_o
  , output logic [PERF_CNT_W-1:0] flush_cnt_o
`endif
);

  localparam int CNT_W = $clog2(hz_max(LOAD_STALL_CYCLES, FLUSH_CYCLES)) + 1;
  // Counter holds the cycles still to go after the current one, hence the -2.
  localparam logic [CNT_W-1:0] LS_RELOAD =
    CNT_W'((LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] FL_RELOAD =
    CNT_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  logic [1:0]       state, state_nxt;
  logic [3:0]       hz_out;
  logic             ld_hz, redir;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  assign ld_hz = mem_read_idex_i && (rt_idex_i != '0) &&
                 ((rs_used_i && (rt_idex_i == rs_ifid_i)) ||
                  (rt_used_i && (rt_idex_i == rt_ifid_i)));
  assign redir = branch_i || jmp_i || topc_i;

  // A redirect wins in every state; it restarts the flush window.
  always_comb begin
    state_nxt = state;
    hz_out    = HZ_OUT_NONE;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    if (redir) begin
      hz_out = HZ_OUT_FLUSH;
      if (FLUSH_CYCLES > 1) begin
        state_nxt = HZ_FLUSH;
        cnt_load  = 1'b1;
        cnt_val   = FL_RELOAD;
      end else begin
        state_nxt = HZ_IDLE;
      end
    end else begin
      case (state)
        HZ_LSTALL, HZ_FLUSH: begin
          hz_out = (state == HZ_LSTALL) ? HZ_OUT_STALL : HZ_OUT_FLUSH;
          if (cnt_zero) state_nxt = HZ_IDLE;
          else          cnt_dec   = 1'b1;
        end
        default: begin
          if (ld_hz) begin
            hz_out = HZ_OUT_STALL;
            if (LOAD_STALL_CYCLES > 1) begin
              state_nxt = HZ_LSTALL;
              cnt_load  = 1'b1;
              cnt_val   = LS_RELOAD;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= HZ_IDLE;
    else        state <= state_nxt;
  end

  hazard_countdown #(.W(CNT_W)) u_countdown (
    .clk   (clk),
    .rst_n (reset),
    .load  (cnt_load),
    .value (cnt_val),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  // Outputs are squashed while reset is held, not just after the next edge.
  assign {ctrl_zero_o, ifid_stall_o, pc_stall_o, flush_o} = reset ? hz_out : HZ_OUT_NONE;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (pc_stall_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_o && (flush_cnt_o != '1))    flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`endif

endmodule
